// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one command (read or write burst) into a single
// AXI4 INCR burst, streams the payload through, and reports one completion
// status. Commands that are misaligned or would cross a 4 KB page are
// rejected without touching the bus.
module axi4_burst_master #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5
) (
  input  logic                   clock,
  input  logic                   reset,

  // command
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_BITS-1:0]   cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [ID_BITS-1:0]     cmd_id,

  // write payload
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [DATA_BITS-1:0]   wdata_bits,

  // read payload
  output logic                   rdata_valid,
  input  logic                   rdata_ready,
  output logic [DATA_BITS-1:0]   rdata_bits,
  output logic                   rdata_last,

  // completion
  output logic                   done_valid,
  output logic [1:0]             done_resp,

  // AXI4 write address
  output logic                   axi_aw_valid,
  input  logic                   axi_aw_ready,
  output logic [ID_BITS-1:0]     axi_aw_bits_id,
  output logic [ADDR_BITS-1:0]   axi_aw_bits_addr,
  output logic [7:0]             axi_aw_bits_len,
  output logic [2:0]             axi_aw_bits_size,
  output logic [1:0]             axi_aw_bits_burst,
  output logic                   axi_aw_bits_lock,
  output logic [3:0]             axi_aw_bits_cache,
  output logic [2:0]             axi_aw_bits_prot,
  output logic [3:0]             axi_aw_bits_qos,

  // AXI4 write data
  output logic                   axi_w_valid,
  input  logic                   axi_w_ready,
  output logic [DATA_BITS-1:0]   axi_w_bits_data,
  output logic [DATA_BITS/8-1:0] axi_w_bits_strb,
  output logic                   axi_w_bits_last,

  // AXI4 write response
  input  logic                   axi_b_valid,
  output logic                   axi_b_ready,
  input  logic [ID_BITS-1:0]     axi_b_bits_id,
  input  logic [1:0]             axi_b_bits_resp,

  // AXI4 read address
  output logic                   axi_ar_valid,
  input  logic                   axi_ar_ready,
  output logic [ID_BITS-1:0]     axi_ar_bits_id,
  output logic [ADDR_BITS-1:0]   axi_ar_bits_addr,
  output logic [7:0]             axi_ar_bits_len,
  output logic [2:0]             axi_ar_bits_size,
  output logic [1:0]             axi_ar_bits_burst,
  output logic                   axi_ar_bits_lock,
  output logic [3:0]             axi_ar_bits_cache,
  output logic [2:0]             axi_ar_bits_prot,
  output logic [3:0]             axi_ar_bits_qos,

  // AXI4 read data
  input  logic                   axi_r_valid,
  output logic                   axi_r_ready,
  input  logic [ID_BITS-1:0]     axi_r_bits_id,
  input  logic [DATA_BITS-1:0]   axi_r_bits_data,
  input  logic [1:0]             axi_r_bits_resp,
  input  logic                   axi_r_bits_last
);

  localparam int WORD = DATA_BITS / 8;
  localparam int SIZE = $clog2(WORD);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_AR    = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_AW    = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_B     = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]           state, state_nx;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           len_q;
  logic [ID_BITS-1:0]   id_q;
  logic                 write_q;
  logic [7:0]           cnt;
  logic [1:0]           status;

  logic                 cmd_hs, r_hs, w_hs, b_hs;
  logic                 last_beat;
  logic                 misalign, cross_page, reject;
  logic [19:0]          span, end_off;
  logic                 r_err, b_err;
  logic [1:0]           r_status, b_status;

  // Responses are ordered by severity, so the worst seen is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Protocol violations are reported as at least SLVERR.
  function automatic logic [1:0] raise_err(input logic [1:0] r, input logic err);
    return (err && r < RESP_SLVERR) ? RESP_SLVERR : r;
  endfunction

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign r_hs      = axi_r_valid & axi_r_ready;
  assign w_hs      = axi_w_valid & axi_w_ready;
  assign b_hs      = axi_b_valid & axi_b_ready;
  assign last_beat = (cnt == len_q);

  // Burst legality: word aligned, and last byte stays inside the 4 KB page.
  assign misalign   = |(addr_q & ADDR_BITS'(WORD - 1));
  assign span       = (20'(len_q) + 20'd1) << SIZE;
  assign end_off    = 20'(addr_q[11:0]) + span;
  assign cross_page = (end_off > 20'd4096);
  assign reject     = misalign | cross_page;

  // Beat sanity: ID must match the request and RLAST must land on the final beat.
  assign r_err    = (axi_r_bits_id != id_q) | (axi_r_bits_last != last_beat);
  assign b_err    = (axi_b_bits_id != id_q);
  assign r_status = raise_err(resp_max(status, axi_r_bits_resp), r_err);
  assign b_status = raise_err(resp_max(status, axi_b_bits_resp), b_err);

  // Next-state selection for the burst sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_hs) state_nx = S_CHECK;
      S_CHECK: begin
        if (reject)       state_nx = S_DONE;
        else if (write_q) state_nx = S_AW;
        else              state_nx = S_AR;
      end
      S_AR:    if (axi_ar_ready)        state_nx = S_RD;
      S_RD:    if (r_hs && last_beat)   state_nx = S_DONE;
      S_AW:    if (axi_aw_ready)        state_nx = S_WR;
      S_WR:    if (w_hs && last_beat)   state_nx = S_B;
      S_B:     if (b_hs)                state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, latched command, beat counter and running status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      write_q <= 1'b0;
      cnt     <= '0;
      status  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (cmd_hs) begin
          addr_q  <= cmd_addr;
          len_q   <= cmd_len;
          id_q    <= cmd_id;
          write_q <= cmd_write;
          cnt     <= '0;
          status  <= '0;
        end
        S_CHECK: if (reject) status <= RESP_SLVERR;
        S_RD: if (r_hs) begin
          // saturate rather than wrap on a 256-beat burst
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          status <= r_status;
        end
        S_WR: if (w_hs) begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end
        S_B: if (b_hs) status <= b_status;
        default: ;
      endcase
    end
  end

  // Command side: only idle accepts work, and never while held in reset.
  assign cmd_ready  = reset & (state == S_IDLE);
  assign done_valid = (state == S_DONE);
  assign done_resp  = (state == S_DONE) ? status : 2'b00;

  // Address channels driven straight from the latched command so the
  // fields stay stable while valid waits for ready.
  assign axi_aw_valid      = (state == S_AW);
  assign axi_aw_bits_id    = id_q;
  assign axi_aw_bits_addr  = addr_q;
  assign axi_aw_bits_len   = len_q;
  assign axi_aw_bits_size  = 3'(SIZE);
  assign axi_aw_bits_burst = 2'b01;
  assign axi_aw_bits_lock  = 1'b0;
  assign axi_aw_bits_cache = 4'd0;
  assign axi_aw_bits_prot  = 3'd0;
  assign axi_aw_bits_qos   = 4'd0;

  assign axi_ar_valid      = (state == S_AR);
  assign axi_ar_bits_id    = id_q;
  assign axi_ar_bits_addr  = addr_q;
  assign axi_ar_bits_len   = len_q;
  assign axi_ar_bits_size  = 3'(SIZE);
  assign axi_ar_bits_burst = 2'b01;
  assign axi_ar_bits_lock  = 1'b0;
  assign axi_ar_bits_cache = 4'd0;
  assign axi_ar_bits_prot  = 3'd0;
  assign axi_ar_bits_qos   = 4'd0;

  // Write data is a pass-through, opened only after AW has been accepted.
  assign axi_w_valid     = (state == S_WR) & wdata_valid;
  assign wdata_ready     = (state == S_WR) & axi_w_ready;
  assign axi_w_bits_data = wdata_bits;
  assign axi_w_bits_strb = '1;
  assign axi_w_bits_last = last_beat;

  assign axi_b_ready = (state == S_B);

  // Read data is a pass-through; last is derived from our own count.
  assign rdata_valid = (state == S_RD) & axi_r_valid;
  assign axi_r_ready = (state == S_RD) & rdata_ready;
  assign rdata_bits  = axi_r_bits_data;
  assign rdata_last  = (state == S_RD) & last_beat;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: read burst, single write, page-cross
// and misaligned rejects, throttled read with an error beat, and reset
// mid-write followed by a clean read.
module tb_axi4_burst_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [4:0]  cmd_id;
  logic        wdata_valid, wdata_ready;
  logic [63:0] wdata_bits;
  logic        rdata_valid, rdata_ready, rdata_last;
  logic [63:0] rdata_bits;
  logic        done_valid;
  logic [1:0]  done_resp;

  logic        axi_aw_valid, axi_aw_ready, axi_aw_bits_lock;
  logic [4:0]  axi_aw_bits_id;
  logic [31:0] axi_aw_bits_addr;
  logic [7:0]  axi_aw_bits_len;
  logic [2:0]  axi_aw_bits_size, axi_aw_bits_prot;
  logic [1:0]  axi_aw_bits_burst;
  logic [3:0]  axi_aw_bits_cache, axi_aw_bits_qos;
  logic        axi_w_valid, axi_w_ready, axi_w_bits_last;
  logic [63:0] axi_w_bits_data;
  logic [7:0]  axi_w_bits_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [4:0]  axi_b_bits_id;
  logic [1:0]  axi_b_bits_resp;
  logic        axi_ar_valid, axi_ar_ready, axi_ar_bits_lock;
  logic [4:0]  axi_ar_bits_id;
  logic [31:0] axi_ar_bits_addr;
  logic [7:0]  axi_ar_bits_len;
  logic [2:0]  axi_ar_bits_size, axi_ar_bits_prot;
  logic [1:0]  axi_ar_bits_burst;
  logic [3:0]  axi_ar_bits_cache, axi_ar_bits_qos;
  logic        axi_r_valid, axi_r_ready, axi_r_bits_last;
  logic [4:0]  axi_r_bits_id;
  logic [63:0] axi_r_bits_data;
  logic [1:0]  axi_r_bits_resp;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ar_cnt = 0;
  int dsnap;
  int k;

  axi4_burst_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_bits(wdata_bits),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_bits(rdata_bits),
    .rdata_last(rdata_last), .done_valid(done_valid), .done_resp(done_resp),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_bits_id(axi_aw_bits_id),
    .axi_aw_bits_addr(axi_aw_bits_addr), .axi_aw_bits_len(axi_aw_bits_len),
    .axi_aw_bits_size(axi_aw_bits_size), .axi_aw_bits_burst(axi_aw_bits_burst),
    .axi_aw_bits_lock(axi_aw_bits_lock), .axi_aw_bits_cache(axi_aw_bits_cache),
    .axi_aw_bits_prot(axi_aw_bits_prot), .axi_aw_bits_qos(axi_aw_bits_qos),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_bits_data(axi_w_bits_data),
    .axi_w_bits_strb(axi_w_bits_strb), .axi_w_bits_last(axi_w_bits_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_bits_id(axi_b_bits_id),
    .axi_b_bits_resp(axi_b_bits_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_bits_id(axi_ar_bits_id),
    .axi_ar_bits_addr(axi_ar_bits_addr), .axi_ar_bits_len(axi_ar_bits_len),
    .axi_ar_bits_size(axi_ar_bits_size), .axi_ar_bits_burst(axi_ar_bits_burst),
    .axi_ar_bits_lock(axi_ar_bits_lock), .axi_ar_bits_cache(axi_ar_bits_cache),
    .axi_ar_bits_prot(axi_ar_bits_prot), .axi_ar_bits_qos(axi_ar_bits_qos),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_bits_id(axi_r_bits_id),
    .axi_r_bits_data(axi_r_bits_data), .axi_r_bits_resp(axi_r_bits_resp),
    .axi_r_bits_last(axi_r_bits_last)
  );

  always #5 clock = ~clock;

  // count completion pulses and AR handshakes mid-cycle, away from the edge
  always @(negedge clock) begin
    if (done_valid) done_cnt = done_cnt + 1;
    if (axi_ar_valid && axi_ar_ready) ar_cnt = ar_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [4:0] id);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    wdata_valid = 0; wdata_bits = 0; rdata_ready = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_bits_id = 0; axi_b_bits_resp = 0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_bits_id = 0; axi_r_bits_data = 0;
    axi_r_bits_resp = 0; axi_r_bits_last = 0;

    // ---- reset ----
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_ar_valid", 64'(axi_ar_valid), 64'd0);
    chk("rst_aw_valid", 64'(axi_aw_valid), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_resp", 64'(done_resp), 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // ---- read 0x1000 len 3, OKAY ----
    send_cmd(1'b0, 32'h1000, 8'd3, 5'd5);
    tick(); cmd_valid = 0;                       // CHECK
    chk("rd1_check_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rd1_check_ar_valid", 64'(axi_ar_valid), 64'd0);
    tick();                                      // T+2: AR
    chk("rd1_ar_valid", 64'(axi_ar_valid), 64'd1);
    chk("rd1_ar_addr", 64'(axi_ar_bits_addr), 64'h1000);
    chk("rd1_ar_len", 64'(axi_ar_bits_len), 64'd3);
    chk("rd1_ar_size", 64'(axi_ar_bits_size), 64'd3);
    chk("rd1_ar_burst", 64'(axi_ar_bits_burst), 64'd1);
    chk("rd1_ar_id", 64'(axi_ar_bits_id), 64'd5);
    tick();                                      // ready low: must hold
    chk("rd1_ar_hold_valid", 64'(axi_ar_valid), 64'd1);
    chk("rd1_ar_hold_addr", 64'(axi_ar_bits_addr), 64'h1000);
    axi_ar_ready = 1; tick(); axi_ar_ready = 0;  // RD
    chk("rd1_ar_drop", 64'(axi_ar_valid), 64'd0);
    rdata_ready = 1;
    for (int i = 0; i < 4; i++) begin
      axi_r_valid = 1; axi_r_bits_data = 64'hA0 + 64'(i); axi_r_bits_id = 5;
      axi_r_bits_resp = 0; axi_r_bits_last = (i == 3);
      #1;
      chk("rd1_rvalid", 64'(rdata_valid), 64'd1);
      chk("rd1_rbits", rdata_bits, 64'hA0 + 64'(i));
      chk("rd1_rlast", 64'(rdata_last), 64'(i == 3));
      tick();
    end
    axi_r_valid = 0; rdata_ready = 0;
    chk("rd1_done_valid", 64'(done_valid), 64'd1);
    chk("rd1_done_resp", 64'(done_resp), 64'd0);
    tick();
    chk("rd1_done_pulse_end", 64'(done_valid), 64'd0);
    chk("rd1_idle_ready", 64'(cmd_ready), 64'd1);
    chk("rd1_ar_count", 64'(ar_cnt), 64'd1);

    // ---- write 0x2000 len 0, B resp EXOKAY ----
    wdata_valid = 1; wdata_bits = 64'h1122334455667788; axi_w_ready = 1;
    send_cmd(1'b1, 32'h2000, 8'd0, 5'd3);
    tick(); cmd_valid = 0;                       // CHECK
    chk("wr1_check_wvalid", 64'(axi_w_valid), 64'd0);
    chk("wr1_check_wready", 64'(wdata_ready), 64'd0);
    tick();                                      // AW
    chk("wr1_aw_valid", 64'(axi_aw_valid), 64'd1);
    chk("wr1_aw_addr", 64'(axi_aw_bits_addr), 64'h2000);
    chk("wr1_aw_len", 64'(axi_aw_bits_len), 64'd0);
    chk("wr1_aw_size", 64'(axi_aw_bits_size), 64'd3);
    chk("wr1_aw_burst", 64'(axi_aw_bits_burst), 64'd1);
    chk("wr1_w_before_aw", 64'(axi_w_valid), 64'd0);
    axi_aw_ready = 1; tick(); axi_aw_ready = 0;  // WR
    chk("wr1_aw_drop", 64'(axi_aw_valid), 64'd0);
    chk("wr1_wvalid", 64'(axi_w_valid), 64'd1);
    chk("wr1_wready", 64'(wdata_ready), 64'd1);
    chk("wr1_wlast", 64'(axi_w_bits_last), 64'd1);
    chk("wr1_wstrb", 64'(axi_w_bits_strb), 64'hFF);
    chk("wr1_wdata", axi_w_bits_data, 64'h1122334455667788);
    tick(); wdata_valid = 0; axi_w_ready = 0;    // B
    chk("wr1_b_wvalid", 64'(axi_w_valid), 64'd0);
    chk("wr1_bready", 64'(axi_b_ready), 64'd1);
    tick();
    chk("wr1_bready_hold", 64'(axi_b_ready), 64'd1);
    chk("wr1_no_early_done", 64'(done_valid), 64'd0);
    axi_b_valid = 1; axi_b_bits_resp = 2'b01; axi_b_bits_id = 3;
    tick(); axi_b_valid = 0;                     // U+1: DONE
    chk("wr1_done_valid", 64'(done_valid), 64'd1);
    chk("wr1_done_resp", 64'(done_resp), 64'd1);
    chk("wr1_bready_off", 64'(axi_b_ready), 64'd0);
    tick();

    // ---- read 0x0FF8 len 1: 0xFF8 + 16 > 4096, rejected ----
    send_cmd(1'b0, 32'h0FF8, 8'd1, 5'd0);
    tick(); cmd_valid = 0;
    chk("x4k_check_done", 64'(done_valid), 64'd0);
    tick();                                      // third cycle counting the handshake
    chk("x4k_done_valid", 64'(done_valid), 64'd1);
    chk("x4k_done_resp", 64'(done_resp), 64'd2);
    chk("x4k_no_ar", 64'(axi_ar_valid), 64'd0);
    tick();
    chk("x4k_idle", 64'(cmd_ready), 64'd1);
    chk("x4k_ar_count", 64'(ar_cnt), 64'd1);

    // ---- misaligned read 0x1004 len 0, rejected ----
    send_cmd(1'b0, 32'h1004, 8'd0, 5'd0);
    tick(); cmd_valid = 0;
    tick();
    chk("mis_done_valid", 64'(done_valid), 64'd1);
    chk("mis_done_resp", 64'(done_resp), 64'd2);
    chk("mis_no_ar", 64'(axi_ar_valid), 64'd0);
    tick();

    // ---- read len 7, beat 3 SLVERR, rdata_ready toggling ----
    send_cmd(1'b0, 32'h3000, 8'd7, 5'd7);
    tick(); cmd_valid = 0;
    tick();
    chk("rd7_ar_len", 64'(axi_ar_bits_len), 64'd7);
    axi_ar_ready = 1; tick(); axi_ar_ready = 0;
    k = 0;
    axi_r_valid = 1;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      rdata_ready = (cyc % 2 == 1);
      axi_r_bits_data = 64'h100 + 64'(k); axi_r_bits_id = 7;
      axi_r_bits_resp = (k == 3) ? 2'b10 : 2'b00; axi_r_bits_last = (k == 7);
      #1;
      chk("rd7_rvalid", 64'(rdata_valid), 64'd1);
      chk("rd7_rbits", rdata_bits, 64'h100 + 64'(k));
      chk("rd7_rlast", 64'(rdata_last), 64'(k == 7));
      chk("rd7_rready", 64'(axi_r_ready), 64'(rdata_ready));
      tick();
      if (rdata_ready) k = k + 1;
    end
    axi_r_valid = 0; rdata_ready = 0;
    chk("rd7_beats", 64'(k), 64'd8);
    chk("rd7_done_valid", 64'(done_valid), 64'd1);
    chk("rd7_done_resp", 64'(done_resp), 64'd2);
    tick();

    // ---- write len 15, reset after beat 5 ----
    send_cmd(1'b1, 32'h4000, 8'd15, 5'd1);
    tick(); cmd_valid = 0;
    tick();
    axi_aw_ready = 1; tick(); axi_aw_ready = 0;  // WR
    wdata_valid = 1; axi_w_ready = 1;
    for (int i = 0; i < 6; i++) begin
      wdata_bits = 64'(i);
      #1;
      chk("wr15_wvalid", 64'(axi_w_valid), 64'd1);
      chk("wr15_wlast", 64'(axi_w_bits_last), 64'd0);
      tick();
    end
    dsnap = done_cnt;
    reset = 1'b0;
    #1;
    chk("rst_mid_wvalid", 64'(axi_w_valid), 64'd0);
    chk("rst_mid_wready", 64'(wdata_ready), 64'd0);
    chk("rst_mid_aw", 64'(axi_aw_valid), 64'd0);
    chk("rst_mid_ar", 64'(axi_ar_valid), 64'd0);
    chk("rst_mid_bready", 64'(axi_b_ready), 64'd0);
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_mid_done", 64'(done_valid), 64'd0);
    wdata_valid = 0; axi_w_ready = 0;
    tick(); tick(); tick();
    chk("rst_mid_no_pulse", 64'(done_cnt), 64'(dsnap));
    reset = 1'b1;
    #1;
    chk("rst_mid_release_ready", 64'(cmd_ready), 64'd1);

    // ---- read 0x0FF8 len 0: ends exactly on the page boundary ----
    send_cmd(1'b0, 32'h0FF8, 8'd0, 5'd2);
    tick(); cmd_valid = 0;
    tick();
    chk("fit_ar_valid", 64'(axi_ar_valid), 64'd1);
    chk("fit_ar_addr", 64'(axi_ar_bits_addr), 64'h0FF8);
    chk("fit_ar_len", 64'(axi_ar_bits_len), 64'd0);
    axi_ar_ready = 1; tick(); axi_ar_ready = 0;
    axi_r_valid = 1; axi_r_bits_data = 64'hBEEF; axi_r_bits_id = 2;
    axi_r_bits_resp = 0; axi_r_bits_last = 1; rdata_ready = 1;
    #1;
    chk("fit_rvalid", 64'(rdata_valid), 64'd1);
    chk("fit_rlast", 64'(rdata_last), 64'd1);
    chk("fit_rbits", rdata_bits, 64'hBEEF);
    tick(); axi_r_valid = 0; rdata_ready = 0;
    chk("fit_done_valid", 64'(done_valid), 64'd1);
    chk("fit_done_resp", 64'(done_resp), 64'd0);
    tick();
    chk("fit_done_count", 64'(done_cnt), 64'(dsnap + 1));
    chk("total_ar_count", 64'(ar_cnt), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
